// File: rtl/muldiv_hilo_if.sv
// EX-stage request/response bundle for the multi-cycle multiply/divide unit and its HI/LO registers.
// master = pipeline side (issues, writes HI/LO); slave = the unit.
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             flush;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, x, y, flush, mthi_we, mtlo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, x, y, flush, mthi_we, mtlo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers (optional MULDIV_FAST_MUL_EN).
// Latency: WIDTH+1 edges from the accepting edge to done (multiply 2 edges with MULDIV_FAST_MUL_EN).
// Backpressure: none queued; busy stalls the pipeline and start/HI-LO writes are ignored while busy.
module muldiv_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_hilo_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE, MULQ} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             div_q, sq, sr, dz;
    logic [WIDTH-1:0] d, ph, pl, hi_q, lo_q;

    logic             idle_like, accept, last, xs, ys;
    logic [WIDTH-1:0] xm, ym;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign accept    = idle_like && bus.start && !bus.flush;
    assign last      = (cnt == CNT_W'(WIDTH - 1));
    assign xs        = !bus.op[0] && bus.x[WIDTH-1];
    assign ys        = !bus.op[0] && bus.y[WIDTH-1];
    assign xm        = xs ? -bus.x : bus.x;
    assign ym        = ys ? -bus.y : bus.y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt = bus.op[1] ? CALC : MULQ;
`else
                    state_nxt = CALC;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC:    state_nxt = bus.flush ? IDLE : (last ? DONE : CALC);
            MULQ:    state_nxt = bus.flush ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: ph:pl is the shifting product (multiply) or remainder:dividend/quotient (divide).
    logic [WIDTH:0]   sum, sh;
    logic [WIDTH-1:0] diff, nph, npl;
    logic             ge;

    always_comb begin
        sum  = {1'b0, ph} + (pl[0] ? {1'b0, d} : '0);
        sh   = {ph, pl[WIDTH-1]};
        ge   = (sh >= {1'b0, d});
        diff = sh[WIDTH-1:0] - d;
        if (div_q) begin
            nph = ge ? diff : sh[WIDTH-1:0];
            npl = {pl[WIDTH-2:0], ge};
        end else begin
            nph = sum[WIDTH:1];
            npl = {sum[0], pl[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the finished magnitudes; a zero divisor forces an all-ones quotient.
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod = (state == MULQ) ? ({{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, pl}) : {nph, npl};
`else
        prod = {nph, npl};
`endif
        prod_s = sq ? -prod : prod;
        quo    = dz ? '1 : (sq ? -npl : npl);
        rem    = sr ? -nph : nph;
        res_hi = div_q ? rem : prod_s[2*WIDTH-1:WIDTH];
        res_lo = div_q ? quo : prod_s[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            div_q <= 1'b0;
            sq    <= 1'b0;
            sr    <= 1'b0;
            dz    <= 1'b0;
            d     <= '0;
            ph    <= '0;
            pl    <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (idle_like) begin
            if (bus.mthi_we) hi_q <= bus.wdata;
            if (bus.mtlo_we) lo_q <= bus.wdata;
            if (accept) begin
                cnt   <= '0;
                div_q <= bus.op[1];
                sq    <= xs ^ ys;
                sr    <= xs;
                dz    <= bus.op[1] && (bus.y == '0);
                d     <= bus.op[1] ? ym : xm;
                pl    <= bus.op[1] ? xm : ym;
                ph    <= '0;
            end
        end else if (!bus.flush) begin
            if (state == CALC) begin
                ph  <= nph;
                pl  <= npl;
                cnt <= cnt + CNT_W'(1);
            end
            if (state_nxt == DONE) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    assign bus.busy = (state == CALC) || (state == MULQ);
    assign bus.done = (state == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed plus randomized checks of muldiv_hilo against an arithmetic reference model.
module tb_muldiv_hilo;

    logic clk;
    logic rst_n;
    int   ncmp;
    int   nfail;

    muldiv_hilo_if #(.WIDTH(32)) bus ();

    muldiv_hilo #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {hi,lo} straight from the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin q = sa * sb; p = q; end
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
        return o[1] ? 32 : 1;
`else
        return (o == 2'b00) ? 32 : 32;
`endif
    endfunction

    // Called at a quiet time with the unit idle; returns after the done pulse has ended.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        int edges;
        int bcnt;
        logic [63:0] e;
        e = model(o, a, b);
        bus.start = 1'b1; bus.op = o; bus.x = a; bus.y = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bcnt  = bus.busy ? 1 : 0;
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            edges = k;
            if (bus.done) break;
            if (bus.busy) bcnt++;
        end
        chk({tag, "_latency"}, 64'(edges), 64'(exp_lat(o)));
        chk({tag, "_busycyc"}, 64'(bcnt), 64'(exp_lat(o)));
        chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, e[63:32]});
        chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, e[31:0]});
        @(posedge clk); #1;
        chk({tag, "_donepulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        logic [31:0] hi_s, lo_s, rx, ry;
        logic [1:0]  ro;
        logic [63:0] e;
        int          edges;
        logic        saw_done;
        ncmp = 0; nfail = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.x = '0; bus.y = '0; bus.flush = 1'b0;
        bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", {32'd0, bus.hi}, 64'd0);
        chk("reset_lo", {32'd0, bus.lo}, 64'd0);
        chk("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        chk("multu_max_hi_const", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFE);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        chk("mult_neg_lo_const", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFEB);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
        chk("div_neg_lo_const", {32'd0, bus.lo}, 64'h0000_0000_FFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd7, "divu");
        chk("divu_hi_const", {32'd0, bus.hi}, 64'd2);
        run_op(2'b11, 32'h1234, 32'd0, "divu_by0");
        run_op(2'b10, 32'hF000_0000, 32'd0, "div_by0_neg");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        chk("div_ovf_lo_const", {32'd0, bus.lo}, 64'h0000_0000_8000_0000);

        // HI write in IDLE, then an aborted divide must leave HI/LO alone
        bus.mthi_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        bus.mthi_we = 1'b0;
        chk("mthi_idle", {32'd0, bus.hi}, 64'h0000_0000_A5A5_A5A5);
        lo_s = bus.lo;
        bus.start = 1'b1; bus.op = 2'b11; bus.x = 32'd9; bus.y = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_busy", {63'd0, bus.busy}, 64'd0);
        saw_done = bus.done;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("flush_nodone", {63'd0, saw_done}, 64'd0);
        chk("flush_hi", {32'd0, bus.hi}, 64'h0000_0000_A5A5_A5A5);
        chk("flush_lo", {32'd0, bus.lo}, {32'd0, lo_s});

        // Flush coinciding with the final iteration edge wins
        hi_s = bus.hi;
        bus.start = 1'b1; bus.op = 2'b10; bus.x = 32'hFFFF_FF00; bus.y = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (31) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_last_state", {62'd0, bus.busy, bus.done}, 64'd0);
        chk("flush_last_hilo", {bus.hi, bus.lo}, {hi_s, lo_s});

        // Flush in IDLE cancels a coincident start
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b11; bus.x = 32'd50; bus.y = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_idle_start", {62'd0, bus.busy, bus.done}, 64'd0);

        // New start and an LO write while calculating are both ignored
        e = model(2'b11, 32'd1000, 32'd7);
        bus.start = 1'b1; bus.op = 2'b11; bus.x = 32'd1000; bus.y = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'b01; bus.x = 32'hFFFF_FFFF; bus.y = 32'hFFFF_FFFF;
        bus.mtlo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mtlo_we = 1'b0;
        edges = 4;
        while (!bus.done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("calc_ignore_latency", 64'(edges), 64'd32);
        chk("calc_ignore_hilo", {bus.hi, bus.lo}, e);
        @(posedge clk); #1;

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'd0;
                1: ry = $urandom_range(1, 15);
                2: rx = 32'h8000_0000;
                3: ry = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(ro, rx, ry, "rand");
        end

        // Asynchronous reset in the middle of a calculation
        bus.start = 1'b1; bus.op = 2'b10; bus.x = 32'hFFFF_0000; bus.y = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("midreset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, "post_reset_mult");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- Multi-cycle multiply/divide responder with architectural HI/LO registers. It is the sequential counterpart to the pipeline's combinational ALU.
- The EX stage issues MULT/MULTU/DIV/DIVU as a start request and stalls on busy.
- The unit iterates and writes the 64-bit result into HI/LO. MFHI/MFLO read hi/lo directly; MTHI/MTLO write them.
- Sits beside the ALU in EX; it replaces the single-cycle x*y and x/y paths.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue request; sampled only in IDLE or DONE
- op  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
- x  in  WIDTH  operand rs (multiplicand / dividend)
- y  in  WIDTH  operand rt (multiplier / divisor)
- flush  in  1  abort the in-flight operation
- mthi_we  in  1  write wdata to HI
- mtlo_we  in  1  write wdata to LO
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress; the pipeline stalls on it
- done  out  1  one-cycle pulse when HI/LO have been updated by an operation
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and datapath registers cleared. Deassertion is synchronous to clk.
- States: IDLE, CALC, DONE.
- IDLE or DONE with start=1 at edge E0:
  - latch op, |x|, |y| (magnitudes for signed ops; raw values for unsigned), and the result sign bits;
  - go to CALC with busy=1 after E0.
- IDLE or DONE with start=0: go to / stay in IDLE.
- CALC runs exactly WIDTH cycles: one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
- At edge E_WIDTH: CALC→DONE. HI/LO are loaded on this edge, and in DONE busy=0, done=1. Latency from accepting edge to done is WIDTH+1 edges including E0.
- Results:
  - multiply: {hi,lo} = 64-bit product, two's complement for MULT;
  - divide: lo = quotient, hi = remainder;
  - signed divide: quotient is truncated toward zero, and the remainder takes the dividend's sign.
- Divide by zero: no trap. lo = all ones, hi = x (original dividend); still takes WIDTH cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- start while in CALC is ignored, with no queuing.
- flush:
  - in CALC: next state IDLE, busy=0, hi/lo unchanged, no done;
  - in CALC coinciding with the final iteration edge: flush wins;
  - in IDLE/DONE: cancels a coincident start.
- mthi_we/mtlo_we:
  - honoured only in IDLE/DONE, and ignored in CALC (the pipeline guarantees stall);
  - a write coincident with start: the write happens; the later result overwrites it;
  - a write in the same cycle as a DONE transition edge cannot occur, because CALC ignores writes.
- hi/lo change only on reset, the CALC→DONE edge, or an mthi/mtlo write.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU skip CALC. The single-cycle product is computed from the latched operands in a state MULQ, which goes to DONE on the next edge (2-edge latency). Divide is unchanged.
- Undefined: multiply is iterative, with WIDTH+1 latency as above.

Test Plan:
- Reset then MULTU x=0xFFFFFFFF, y=0xFFFFFFFF → done 33 edges after start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 32 cycles.
- MULT x=0xFFFFFFFD (-3), y=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; with MULDIV_FAST_MUL_EN, done on the 2nd edge.
- DIV x=0xFFFFFFF9 (-7), y=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU x=100, y=7 → lo=14, hi=2.
- DIVU x=0x1234, y=0 → lo=0xFFFFFFFF, hi=0x1234; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi_we with wdata=0xA5A5A5A5 in IDLE → hi=0xA5A5A5A5. Then start DIVU 9/2, pulse flush at iteration 10 → busy drops, no done, hi=0xA5A5A5A5, lo unchanged.
- start in CALC with new operands, and mtlo_we in CALC → both ignored; result matches the first operation. Also assert rst_n=0 mid-CALC → outputs zero immediately.
